obstacle_spawner: RTL and testbench
===================================

# obstacle_spawner

Game-logic stage that owns up to four falling obstacles and runs the play/over state machine. Sits between player_control and the renderer: it consumes `player_x` and the `game_en` tick from game_clock_generator, and produces obstacle positions, score and `game_over` for vga_driver_memory to draw. Spawn columns come from an internal 10-bit LFSR; collision with the player box ends the round.

## Interface
- `BOX_WIDTH`, default 30: player box width (px).
- `BOX_HEIGHT`, default 30: player box height (px).
- `BOX_Y_START`, default 315: player box top row.
- `OBJ_SIZE`, default 20: obstacle edge length (square, px).
- `FALL_STEP`, default 2: rows moved per game tick.
- `SPAWN_PERIOD`, default 60: game ticks between spawn attempts.
- `SCREEN_W`, default 640: visible width.
- `SCREEN_H`, default 480: visible height.
- `LFSR_SEED`, default 10'h2A5: nonzero LFSR reset value.

Ports:
- `clk` in 1: 50 MHz system clock.
- `rst` in 1: asynchronous, active-low reset.
- `game_en` in 1: one-clk game tick strobe.
- `start` in 1: start/restart request, sampled each clk.
- `player_x` in 10: player box left column.
- `obj_valid` out 4: bit i set means obstacle i is live.
- `obj_x` out 40: packed, obstacle i at [10i+9:10i].
- `obj_y` out 40: packed, obstacle i top row at [10i+9:10i].
- `score` out 16: obstacles survived, saturates at 16'hFFFF.
- `playing` out 1: high in PLAY.
- `game_over` out 1: high in OVER.

## Operation
- FSM states: IDLE, PLAY, OVER.
  - IDLE -> PLAY when `start`=1. Entry clears all slots, `score` and the spawn counter. The LFSR is not reset.
  - PLAY -> OVER when a collision is detected.
  - OVER -> PLAY when `start`=1, with the same clearing as IDLE -> PLAY. No path back to IDLE except reset.
- Reset: state IDLE, `obj_valid`=0, all `obj_x` and `obj_y`=0, `score`=0, spawn counter=0, LFSR=`LFSR_SEED`, `playing`=0, `game_over`=0.
- Collision is checked every clk in PLAY on the registered values of each live slot. A hit requires all four of:
  - `obj_x` < `player_x`+`BOX_WIDTH`
  - `obj_x`+`OBJ_SIZE` > `player_x`
  - `obj_y` < `BOX_Y_START`+`BOX_HEIGHT`
  - `obj_y`+`OBJ_SIZE` > `BOX_Y_START`
- Compare arithmetic is 11-bit, so sums do not wrap.
- On each `game_en` in PLAY with no collision this cycle:
  - Every live slot gets y += `FALL_STEP`.
  - A slot whose new y is >= `SCREEN_H` is cleared, and `score` increments once per cleared slot, saturating.
  - Spawn counter increments. When it equals `SPAWN_PERIOD`-1 it wraps to 0 and a spawn is attempted.
- Spawn rules:
  - Target is the lowest-index slot that was free before this tick's updates. A slot retiring on the same tick is not reused until the next spawn.
  - No free slot: the spawn is dropped. The counter still wraps and the LFSR does not advance.
  - Spawned slot: y=0, x=L if L < `SCREEN_W`-`OBJ_SIZE`, else L-512, where L is the current LFSR value. The new slot does not move on its spawn tick.
  - After a successful spawn, LFSR <= {L[8:0], L[9]^L[6]}.
- Collision and `game_en` in the same clk: the transition to OVER wins. No movement, retire, score or spawn happens that cycle.
- In OVER and IDLE, positions are frozen and `game_en` is ignored. OVER keeps the obstacles visible.
- `start` held high in PLAY has no effect.

## Timing
- All outputs are registered. Position, score and spawn updates are visible 1 clk after the `game_en` cycle.
- Collision latency: the hit condition holds on the registered values in cycle N, and `game_over`=1, `playing`=0 from cycle N+1.
- Start latency: `start` sampled in cycle N gives `playing`=1 and cleared slots in N+1.
- Async reset takes effect immediately in any state, including mid-spawn. Release is synchronous to `clk`.

## Test plan
- Reset, then `start` pulse, then 4 `game_en` pulses with `SPAWN_PERIOD`=4 and `player_x`=0 → `obj_valid`=4'b0001, obj 0 x=165 (677-512), y=0, `score`=0.
- Continue with 4 more ticks → obj 1 x=331 (LFSR 10'h14B), y=0; obj 0 y=8.
- Obstacle at x=165 and `player_x`=400, ticked until its y reaches 480 (240 moves) → slot cleared, `score`=1, `game_over`=0.
- `player_x`=165 and a single obstacle at x=165 → after 148 moves (y=296) `game_over`=1 one clk later; positions frozen under further `game_en`.
- All four slots live at a spawn tick → spawn dropped, LFSR unchanged, counter wraps to 0. `start` in OVER → `obj_valid`=0, `score`=0, `playing`=1.
- Assert `rst`=0 mid-PLAY, asynchronously between clk edges → all outputs zero immediately; after release the state is IDLE and LFSR=10'h2A5.

Source files
------------

// File: rtl/obstacle_spawner.sv
// Falling-obstacle game stage: four obstacle slots, LFSR spawn columns,
// player collision and the IDLE/PLAY/OVER round state machine.
module obstacle_spawner #(
  parameter int         BOX_WIDTH    = 30,
  parameter int         BOX_HEIGHT   = 30,
  parameter int         BOX_Y_START  = 315,
  parameter int         OBJ_SIZE     = 20,
  parameter int         FALL_STEP    = 2,
  parameter int         SPAWN_PERIOD = 60,
  parameter int         SCREEN_W     = 640,
  parameter int         SCREEN_H     = 480,
  parameter logic [9:0] LFSR_SEED    = 10'h2A5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_en,
  input  logic        start,
  input  logic [9:0]  player_x,
  output logic [3:0]  obj_valid,
  output logic [39:0] obj_x,
  output logic [39:0] obj_y,
  output logic [15:0] score,
  output logic        playing,
  output logic        game_over
);

  localparam logic [10:0] BOX_W_C     = 11'(BOX_WIDTH);
  localparam logic [10:0] BOX_H_C     = 11'(BOX_HEIGHT);
  localparam logic [10:0] BOX_Y_C     = 11'(BOX_Y_START);
  localparam logic [10:0] OBJ_C       = 11'(OBJ_SIZE);
  localparam logic [10:0] STEP_C      = 11'(FALL_STEP);
  localparam logic [10:0] SCR_H_C     = 11'(SCREEN_H);
  localparam logic [10:0] SPAWN_LIM_C = 11'(SCREEN_W - OBJ_SIZE);
  localparam int          CNT_W       = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       valid_q, valid_d;
  logic [9:0]       x_q [4];
  logic [9:0]       x_d [4];
  logic [9:0]       y_q [4];
  logic [9:0]       y_d [4];
  logic [15:0]      score_q, score_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       lfsr_q, lfsr_d;
  logic             playing_q, game_over_q;

  logic [3:0]       hit_vec;
  logic             hit;
  logic             free_found;
  logic [1:0]       free_idx;
  logic [10:0]      ny;
  logic [2:0]       retire_cnt;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {14'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [9:0] lfsr_step(input logic [9:0] l);
    return {l[8:0], l[9] ^ l[6]};
  endfunction

  // Columns past the right edge fold back by 512 so the obstacle stays on screen.
  function automatic logic [9:0] spawn_col(input logic [9:0] l);
    return ({1'b0, l} < SPAWN_LIM_C) ? l : (l - 10'd512);
  endfunction

  // Box overlap on registered slot positions, 11-bit so sums never wrap.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      hit_vec[i] = valid_q[i]
        && ({1'b0, x_q[i]} < ({1'b0, player_x} + BOX_W_C))
        && (({1'b0, x_q[i]} + OBJ_C) > {1'b0, player_x})
        && ({1'b0, y_q[i]} < (BOX_Y_C + BOX_H_C))
        && (({1'b0, y_q[i]} + OBJ_C) > BOX_Y_C);
    end
    hit = (state_q == S_PLAY) && (|hit_vec);
  end

  // Spawn target is chosen from occupancy before this tick's retirements.
  always_comb begin
    free_found = 1'b0;
    free_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = 2'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    x_d        = x_q;
    y_d        = y_q;
    score_d    = score_q;
    cnt_d      = cnt_q;
    lfsr_d     = lfsr_q;
    ny         = 11'd0;
    retire_cnt = 3'd0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d = S_PLAY;
          valid_d = 4'd0;
          for (int i = 0; i < 4; i++) begin
            x_d[i] = 10'd0;
            y_d[i] = 10'd0;
          end
          score_d = 16'd0;
          cnt_d   = '0;
        end
      end

      S_PLAY: begin
        if (hit) begin
          state_d = S_OVER;
        end else if (game_en) begin
          for (int i = 0; i < 4; i++) begin
            if (valid_q[i]) begin
              ny = {1'b0, y_q[i]} + STEP_C;
              if (ny >= SCR_H_C) begin
                valid_d[i] = 1'b0;
                y_d[i]     = 10'd0;
                retire_cnt = retire_cnt + 3'd1;
              end else begin
                y_d[i] = ny[9:0];
              end
            end
          end
          score_d = sat_add(score_q, retire_cnt);

          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (free_found) begin
              valid_d[free_idx] = 1'b1;
              x_d[free_idx]     = spawn_col(lfsr_q);
              y_d[free_idx]     = 10'd0;
              lfsr_d            = lfsr_step(lfsr_q);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      valid_q     <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        x_q[i] <= 10'd0;
        y_q[i] <= 10'd0;
      end
      score_q     <= 16'd0;
      cnt_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      for (int i = 0; i < 4; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
      score_q     <= score_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      playing_q   <= (state_d == S_PLAY);
      game_over_q <= (state_d == S_OVER);
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      obj_x[10*i +: 10] = x_q[i];
      obj_y[10*i +: 10] = y_q[i];
    end
  end

  assign obj_valid = valid_q;
  assign score     = score_q;
  assign playing   = playing_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Bench for obstacle_spawner: spec-level game model compared every cycle,
// plus directed scenarios with hand-computed positions, scores and states.
module tb_obstacle_spawner;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        game_en;
  logic        start;
  logic [9:0]  player_x;
  logic [3:0]  obj_valid;
  logic [39:0] obj_x;
  logic [39:0] obj_y;
  logic [15:0] score;
  logic        playing;
  logic        game_over;

  obstacle_spawner #(.SPAWN_PERIOD(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .game_en   (game_en),
    .start     (start),
    .player_x  (player_x),
    .obj_valid (obj_valid),
    .obj_x     (obj_x),
    .obj_y     (obj_y),
    .score     (score),
    .playing   (playing),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mst 0=idle 1=play 2=over
  int mv[4] = '{0, 0, 0, 0};
  int mx[4] = '{0, 0, 0, 0};
  int my[4] = '{0, 0, 0, 0};
  int mscore = 0;
  int mst    = 0;
  int mcnt   = 0;
  int mlfsr  = 'h2A5;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 0; mx[i] = 0; my[i] = 0;
    end
    mscore = 0; mst = 0; mcnt = 0; mlfsr = 'h2A5;
  endtask

  task automatic model_step();
    int px;
    bit hit;
    int was_free[4];
    int slot;
    px  = int'(player_x);
    hit = 1'b0;
    if (mst == 1) begin
      for (int i = 0; i < 4; i++)
        if (mv[i] != 0 && mx[i] < px + 30 && mx[i] + 20 > px &&
            my[i] < 315 + 30 && my[i] + 20 > 315)
          hit = 1'b1;
      if (hit) begin
        mst = 2;
      end else if (game_en) begin
        for (int i = 0; i < 4; i++) was_free[i] = (mv[i] == 0) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
          if (mv[i] != 0) begin
            my[i] = my[i] + 2;
            if (my[i] >= 480) begin
              mv[i]  = 0;
              mscore = (mscore + 1 > 65535) ? 65535 : mscore + 1;
            end
          end
        end
        if (mcnt == P - 1) begin
          mcnt = 0;
          slot = -1;
          for (int i = 3; i >= 0; i--) if (was_free[i] != 0) slot = i;
          if (slot >= 0) begin
            mv[slot] = 1;
            mx[slot] = (mlfsr < 620) ? mlfsr : mlfsr - 512;
            my[slot] = 0;
            mlfsr = ((mlfsr << 1) & 1023) | (((mlfsr >> 9) ^ (mlfsr >> 6)) & 1);
          end
        end else begin
          mcnt = mcnt + 1;
        end
      end
    end else if (start) begin
      mst = 1;
      for (int i = 0; i < 4; i++) begin
        mv[i] = 0; mx[i] = 0; my[i] = 0;
      end
      mscore = 0;
      mcnt   = 0;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  function automatic int xof(input int i);
    return int'(obj_x[10*i +: 10]);
  endfunction

  function automatic int yof(input int i);
    return int'(obj_y[10*i +: 10]);
  endfunction

  always @(negedge clk) begin : cmp
    bit ok;
    logic [3:0] ev;
    int bad_slot;
    ok = 1'b1;
    bad_slot = -1;
    for (int i = 0; i < 4; i++) ev[i] = (mv[i] != 0);
    if (obj_valid !== ev) ok = 1'b0;
    if (int'(score) != mscore) ok = 1'b0;
    if (playing !== (mst == 1)) ok = 1'b0;
    if (game_over !== (mst == 2)) ok = 1'b0;
    for (int i = 0; i < 4; i++)
      if (mv[i] != 0 && (xof(i) != mx[i] || yof(i) != my[i])) begin
        ok = 1'b0;
        bad_slot = i;
      end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t valid=%b/%b score=%0d/%0d playing=%b/%0d over=%b/%0d slot=%0d",
               $time, obj_valid, ev, score, mscore, playing, (mst == 1), game_over, (mst == 2), bad_slot);
      if (bad_slot >= 0)
        $display("FAIL cycle_model_pos slot=%0d x=%0d/%0d y=%0d/%0d",
                 bad_slot, xof(bad_slot), mx[bad_slot], yof(bad_slot), my[bad_slot]);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    game_en = 1'b1;
    @(negedge clk);
    game_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    game_en  = 1'b0;
    start    = 1'b0;
    player_x = 10'd0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_valid",   int'(obj_valid), 0);
    chk("reset_score",   int'(score), 0);
    chk("reset_playing", int'(playing), 0);
    chk("reset_over",    int'(game_over), 0);
    chk("reset_x_zero",  int'(obj_x == 40'd0), 1);
    chk("reset_y_zero",  int'(obj_y == 40'd0), 1);
    rst = 1'b1;

    pulse_start();
    chk("start_playing", int'(playing), 1);

    repeat (4) tick();
    chk("spawn1_valid", int'(obj_valid), 1);
    chk("spawn1_x",     xof(0), 165);
    chk("spawn1_y",     yof(0), 0);
    chk("spawn1_score", int'(score), 0);

    repeat (4) tick();
    chk("spawn2_valid", int'(obj_valid), 3);
    chk("spawn2_x1",    xof(1), 331);
    chk("spawn2_y1",    yof(1), 0);
    chk("spawn2_y0",    yof(0), 8);

    // Slots fill by tick 16; spawns drop until slot 0 retires at tick 244.
    player_x = 10'd400;
    repeat (236) tick();
    chk("retire_valid", int'(obj_valid), 4'b1110);
    chk("retire_score", int'(score), 1);
    chk("retire_over",  int'(game_over), 0);

    repeat (4) tick();
    chk("reuse_valid", int'(obj_valid), 4'b1101);
    chk("reuse_x0",    xof(0), 606);
    chk("reuse_y0",    yof(0), 0);
    chk("reuse_score", int'(score), 2);

    pulse_start();
    chk("start_in_play_score", int'(score), 2);
    chk("start_in_play_valid", int'(obj_valid), 4'b1101);

    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_valid",   int'(obj_valid), 0);
    chk("async_score",   int'(score), 0);
    chk("async_playing", int'(playing), 0);
    chk("async_x_zero",  int'(obj_x == 40'd0), 1);
    chk("async_y_zero",  int'(obj_y == 40'd0), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_playing", int'(playing), 0);
    chk("idle_over",    int'(game_over), 0);

    player_x = 10'd165;
    pulse_start();
    repeat (4) tick();
    chk("seed_x0", xof(0), 165);

    repeat (148) tick();
    chk("hit_y0",        yof(0), 296);
    chk("hit_over_pre",  int'(game_over), 0);
    chk("hit_play_pre",  int'(playing), 1);
    @(negedge clk);
    chk("hit_over",      int'(game_over), 1);
    chk("hit_play",      int'(playing), 0);

    repeat (3) tick();
    chk("frozen_y0",    yof(0), 296);
    chk("frozen_valid", int'(obj_valid), 4'b1111);

    pulse_start();
    chk("restart_valid",   int'(obj_valid), 0);
    chk("restart_score",   int'(score), 0);
    chk("restart_playing", int'(playing), 1);
    chk("restart_over",    int'(game_over), 0);

    repeat (4) tick();
    chk("restart_lfsr_x0", xof(0), 606);
    chk("restart_valid1",  int'(obj_valid), 1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
